// File: rtl/mac_accumulator.sv
// Signed accumulate stage behind the Booth multiplier: sums a vector of 16-bit
// products and holds the result. Define MAC_ACC_SATURATE_EN to clamp on overflow.
module mac_accumulator #(
   parameter int ACC_W = 24,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   localparam logic [0:0] S_ACCUM = 1'b0;
   localparam logic [0:0] S_HOLD  = 1'b1;

   logic [0:0]       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;

   logic [ACC_W-1:0] w_ext;
   logic [ACC_W-1:0] w_sum;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_ovf;

   assign w_ext = {{(ACC_W-16){in_product[15]}}, in_product};
   assign w_sum = r_acc + w_ext;
   // Overflow only possible when both operands share a sign and the sum flips it.
   assign w_ovf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef MAC_ACC_SATURATE_EN
   assign w_acc_nxt = !w_ovf ? w_sum :
                      (r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}});
`else
   assign w_acc_nxt = w_sum;
`endif

   assign w_cnt_nxt = (&r_count) ? r_count : r_count + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_ACCUM;
         r_acc   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (r_state == S_HOLD) begin
         if (out_ready) begin
            r_state <= S_ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
         end
      end else if (in_valid) begin
         r_acc   <= w_acc_nxt;
         r_count <= w_cnt_nxt;
         if (w_ovf)   r_ovf   <= 1'b1;
         if (in_last) r_state <= S_HOLD;
      end
   end

   assign in_ready  = (r_state == S_ACCUM) && !rst;
   assign out_valid = (r_state == S_HOLD);
   assign out_acc   = r_acc;
   assign out_count = r_count;
   assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed cases with literal
// expectations plus random vectors against a queue-based sum model.
module tb_mac_accumulator;

   localparam int ACC_W = 24;
   localparam int CNT_W = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_product = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   int tests = 0;
   int fails = 0;

   mac_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_product(in_product), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count),
      .out_ovf(out_ovf));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 1;
   localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));
   localparam longint MASK = (64'sd1 <<< ACC_W) - 1;

   longint q[$];
   bit     m_hold = 1'b0;
   longint m_acc = 0;
   longint m_cnt = 0;
   bit     m_ovf = 1'b0;

   function automatic void compute();
      longint a = 0;
      longint s;
      bit o = 1'b0;
      foreach (q[i]) begin
         s = a + q[i];
         if (s > AMAX || s < AMIN) begin
            o = 1'b1;
`ifdef MAC_ACC_SATURATE_EN
            s = (s > AMAX) ? AMAX : AMIN;
`else
            s = s & MASK;
            if (s > AMAX) s = s - (MASK + 1);
`endif
         end
         a = s;
      end
      m_acc = a;
      m_cnt = (q.size() > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : q.size();
      m_ovf = o;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hold = 1'b0;
         q.delete();
      end else if (m_hold) begin
         if (out_ready) begin
            m_hold = 1'b0;
            q.delete();
         end
      end else if (in_valid) begin
         q.push_back(longint'($signed(in_product)));
         if (in_last) begin
            compute();
            m_hold = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", longint'(in_ready), longint'(!m_hold && !rst));
      chk("out_valid", longint'(out_valid), longint'(m_hold));
      if (m_hold) begin
         chk("model_acc", longint'(out_acc), m_acc & MASK);
         chk("model_count", longint'(out_count), m_cnt);
         chk("model_ovf", longint'(out_ovf), longint'(m_ovf));
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and wait until it is taken; releases backpressure if stuck.
   task automatic send(input int p, input bit last);
      bit took = 1'b0;
      int n = 0;
      in_valid = 1'b1;
      in_product = 16'(p);
      in_last = last;
      while (!took && n < 200) begin
         took = in_ready;
         if (n >= 3) out_ready = 1'b1;
         tick();
         n++;
      end
      if (!took) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $finish;
   end

   initial begin
      tick();
      chk("reset_ready", longint'(in_ready), 0);
      chk("reset_acc", longint'(out_acc), 0);
      chk("reset_valid", longint'(out_valid), 0);
      rst = 1'b0;
      #1;
      chk("post_reset_ready", longint'(in_ready), 1);

      // basic sum
      out_ready = 1'b1;
      send(3, 0); send(-5, 0); send(7, 1);
      chk("basic_valid", longint'(out_valid), 1);
      chk("basic_acc", longint'(out_acc), 5);
      chk("basic_count", longint'(out_count), 3);
      chk("basic_ovf", longint'(out_ovf), 0);
      chk("basic_bubble", longint'(in_ready), 0);
      tick();
      chk("basic_ready_again", longint'(in_ready), 1);
      chk("basic_released", longint'(out_valid), 0);

      // backpressure
      out_ready = 1'b0;
      send(100, 1);
      in_valid = 1'b1; in_product = 16'd55;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_acc", longint'(out_acc), 100);
         chk("bp_ready", longint'(in_ready), 0);
         chk("bp_count", longint'(out_count), 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      send(-1, 1);
      chk("bp_neg_acc", longint'(out_acc), 64'hFFFFFF);
      tick();

      // overflow
      for (int i = 0; i < 512; i++) send(16384, i == 511);
`ifdef MAC_ACC_SATURATE_EN
      chk("ovf_acc", longint'(out_acc), 64'h7FFFFF);
`else
      chk("ovf_acc", longint'(out_acc), 64'h800000);
`endif
      chk("ovf_count", longint'(out_count), 512);
      chk("ovf_flag", longint'(out_ovf), 1);
      tick();
      chk("ovf_cleared", longint'(out_ovf), 0);

      // single-term vector
      send(-16256, 1);
      chk("single_acc", longint'(out_acc), 64'hFFC080);
      chk("single_count", longint'(out_count), 1);
      tick();

      // reset mid-vector
      send(50, 0); send(60, 0);
      rst = 1'b1;
      #1;
      chk("rst_acc", longint'(out_acc), 0);
      chk("rst_count", longint'(out_count), 0);
      chk("rst_ready", longint'(in_ready), 0);
      chk("rst_valid", longint'(out_valid), 0);
      tick();
      rst = 1'b0;
      #1;
      send(9, 1);
      chk("rst_then_acc", longint'(out_acc), 9);
      chk("rst_then_count", longint'(out_count), 1);
      tick();

      // simultaneous output handshake and input beat
      out_ready = 1'b0;
      send(1, 1);
      out_ready = 1'b1;
      in_valid = 1'b1; in_product = 16'd4; in_last = 1'b1;
      tick();
      chk("sim_handshake_valid", longint'(out_valid), 0);
      chk("sim_handshake_count", longint'(out_count), 0);
      tick();
      chk("sim_accept_valid", longint'(out_valid), 1);
      chk("sim_accept_acc", longint'(out_acc), 4);
      chk("sim_accept_count", longint'(out_count), 1);
      in_valid = 1'b0; in_last = 1'b0;
      tick();

      // random vectors, random backpressure and bubbles
      for (int v = 0; v < 40; v++) begin
         int len = $urandom_range(1, 8);
         for (int b = 0; b < len; b++) begin
            int p;
            p = (v % 5 == 0) ? 32767 - int'($urandom_range(0, 3))
                             : int'($urandom_range(0, 65535));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) tick();
            send(p, b == len - 1);
         end
      end
      out_ready = 1'b1;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
